// File: rtl/hba_reg_bank_ext.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | hba_reg_bank_ext : HBA slave with RW regs, sampled input regs, change intr  |
// | Revision 1.0                                                                |
// +-----------------------------------------------------------------------------+
module hba_reg_bank_ext #(
  parameter int DBUS_WIDTH        = 8,
  parameter int PERIPH_ADDR_WIDTH = 4,
  parameter int REG_ADDR_WIDTH    = 8,
  parameter int ADDR_WIDTH        = PERIPH_ADDR_WIDTH + REG_ADDR_WIDTH,
  parameter int PERIPH_ADDR       = 0,
  parameter int NUM_REGS          = 4,
  parameter int NUM_IN_REGS       = 2
) (
  input  logic                                                    hba_clk,
  input  logic                                                    hba_reset,
  input  logic                                                    hba_xferstart,
  input  logic                                                    hba_rwn,
  input  logic [ADDR_WIDTH-1:0]                                   hba_abus,
  input  logic [DBUS_WIDTH-1:0]                                   hba_dbus,
  output logic [DBUS_WIDTH-1:0]                                   slave_dbus,
  output logic                                                    slave_xferack,
  output logic                                                    slave_interrupt,
  output logic [NUM_REGS*DBUS_WIDTH-1:0]                          regs_out,
  input  logic [((NUM_IN_REGS > 0) ? NUM_IN_REGS : 1)*DBUS_WIDTH-1:0] regs_in
);

  localparam int IN_REGS_W   = ((NUM_IN_REGS > 0) ? NUM_IN_REGS : 1) * DBUS_WIDTH;
  localparam int CTRL_ADDR   = NUM_REGS + NUM_IN_REGS;
  localparam int STATUS_ADDR = CTRL_ADDR + 1;

  logic                      hit;
  logic                      wr_hit;
  logic                      rd_hit;
  logic                      status_w1c;
  logic [REG_ADDR_WIDTH-1:0] reg_addr;
  logic [DBUS_WIDTH-1:0]     rw_regs [NUM_REGS];
  logic [IN_REGS_W-1:0]      in_q;
  logic                      change_set;
  logic                      intr_en;
  logic                      changed;
  logic                      changed_next;
  logic [DBUS_WIDTH-1:0]     rd_data;

  assign reg_addr = hba_abus[REG_ADDR_WIDTH-1:0];
  assign hit      = hba_xferstart &&
                    (hba_abus[ADDR_WIDTH-1:REG_ADDR_WIDTH] == PERIPH_ADDR_WIDTH'(PERIPH_ADDR));
  assign wr_hit   = hit && !hba_rwn;
  assign rd_hit   = hit && hba_rwn;

  always_ff @(posedge hba_clk) begin
    if (!hba_reset) begin
      for (int i = 0; i < NUM_REGS; i++) rw_regs[i] <= '0;
      intr_en <= 1'b0;
    end else if (wr_hit) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        if (reg_addr == REG_ADDR_WIDTH'(i)) rw_regs[i] <= hba_dbus;
      end
      if (reg_addr == REG_ADDR_WIDTH'(CTRL_ADDR)) intr_en <= hba_dbus[0];
    end
  end

  generate
    for (genvar gi = 0; gi < NUM_REGS; gi++) begin : g_regs_out
      assign regs_out[gi*DBUS_WIDTH +: DBUS_WIDTH] = rw_regs[gi];
    end
  endgenerate

  // in_prev only becomes a meaningful reference after two post-reset edges,
  // so the first sampled value after reset is never reported as a change.
  generate
    if (NUM_IN_REGS > 0) begin : g_in_sample
      logic [IN_REGS_W-1:0] in_prev;
      logic                 in_valid;
      logic                 primed;

      always_ff @(posedge hba_clk) begin
        if (!hba_reset) begin
          in_q     <= '0;
          in_prev  <= '0;
          in_valid <= 1'b0;
          primed   <= 1'b0;
        end else begin
          in_q     <= regs_in;
          in_prev  <= in_q;
          in_valid <= 1'b1;
          primed   <= in_valid;
        end
      end

      assign change_set = primed && (in_q != in_prev);
    end else begin : g_no_in
      assign in_q       = '0;
      assign change_set = 1'b0;
    end
  endgenerate

  always_comb begin
    rd_data = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (reg_addr == REG_ADDR_WIDTH'(i)) rd_data = rw_regs[i];
    end
    for (int j = 0; j < NUM_IN_REGS; j++) begin
      if (reg_addr == REG_ADDR_WIDTH'(NUM_REGS + j)) rd_data = in_q[j*DBUS_WIDTH +: DBUS_WIDTH];
    end
    if (reg_addr == REG_ADDR_WIDTH'(CTRL_ADDR))   rd_data = {{(DBUS_WIDTH-1){1'b0}}, intr_en};
    if (reg_addr == REG_ADDR_WIDTH'(STATUS_ADDR)) rd_data = {{(DBUS_WIDTH-1){1'b0}}, changed};
  end

  // A new change in the same cycle as a W1C keeps the flag set.
  assign status_w1c   = wr_hit && (reg_addr == REG_ADDR_WIDTH'(STATUS_ADDR)) && hba_dbus[0];
  assign changed_next = change_set | (changed & ~status_w1c);

  always_ff @(posedge hba_clk) begin
    if (!hba_reset) begin
      changed         <= 1'b0;
      slave_xferack   <= 1'b0;
      slave_dbus      <= '0;
      slave_interrupt <= 1'b0;
    end else begin
      changed         <= changed_next;
      slave_xferack   <= hit;
      slave_dbus      <= rd_hit ? rd_data : '0;
      slave_interrupt <= intr_en & changed;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_hba_reg_bank_ext.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | tb_hba_reg_bank_ext : self-checking bench, vector table plus scoreboard     |
// | Revision 1.0                                                                |
// +-----------------------------------------------------------------------------+
module tb_hba_reg_bank_ext;

  logic        hba_clk = 1'b0;
  logic        hba_reset;
  logic        hba_xferstart;
  logic        hba_rwn;
  logic [11:0] hba_abus;
  logic [7:0]  hba_dbus;
  logic [7:0]  slave_dbus;
  logic        slave_xferack;
  logic        slave_interrupt;
  logic [31:0] regs_out;
  logic [15:0] regs_in;

  hba_reg_bank_ext #(
    .DBUS_WIDTH(8), .PERIPH_ADDR_WIDTH(4), .REG_ADDR_WIDTH(8), .ADDR_WIDTH(12),
    .PERIPH_ADDR(2), .NUM_REGS(4), .NUM_IN_REGS(2)
  ) dut (
    .hba_clk(hba_clk), .hba_reset(hba_reset), .hba_xferstart(hba_xferstart),
    .hba_rwn(hba_rwn), .hba_abus(hba_abus), .hba_dbus(hba_dbus),
    .slave_dbus(slave_dbus), .slave_xferack(slave_xferack),
    .slave_interrupt(slave_interrupt), .regs_out(regs_out), .regs_in(regs_in)
  );

  always #5 hba_clk = ~hba_clk;

  typedef struct {
    logic        rwn;
    logic [11:0] addr;
    logic [7:0]  wdata;
    logic        exp_ack;
    logic [7:0]  exp_data;
  } vec_t;

  typedef struct {
    logic       ack;
    logic [7:0] data;
  } exp_t;

  exp_t sb[$];
  vec_t tbl[12];
  int   errors = 0;
  int   checks = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Outputs are sampled 1 time unit after the rising edge.
  task automatic tick();
    exp_t e;
    @(posedge hba_clk);
    #1;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      check("xferack", {31'b0, slave_xferack}, {31'b0, e.ack});
      check("slave_dbus", {24'b0, slave_dbus}, {24'b0, e.data});
    end
  endtask

  task automatic xfer(input logic rwn, input logic [11:0] addr, input logic [7:0] wdata,
                      input logic exp_ack, input logic [7:0] exp_data);
    exp_t e;
    hba_xferstart = 1'b1;
    hba_rwn       = rwn;
    hba_abus      = addr;
    hba_dbus      = wdata;
    e.ack  = exp_ack;
    e.data = exp_data;
    sb.push_back(e);
    tick();
    hba_xferstart = 1'b0;
  endtask

  task automatic idle();
    exp_t e;
    hba_xferstart = 1'b0;
    e.ack  = 1'b0;
    e.data = 8'h00;
    sb.push_back(e);
    tick();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset held with a coincident transfer request
    hba_reset     = 1'b0;
    hba_xferstart = 1'b1;
    hba_rwn       = 1'b0;
    hba_abus      = 12'h203;
    hba_dbus      = 8'hFF;
    regs_in       = 16'h0000;
    for (int i = 0; i < 3; i++) begin
      exp_t e;
      e.ack  = 1'b0;
      e.data = 8'h00;
      sb.push_back(e);
      tick();
      check("reset regs_out", regs_out, 32'h0);
      check("reset interrupt", {31'b0, slave_interrupt}, 32'h0);
    end
    hba_reset = 1'b1;
    idle();
    check("post-reset regs_out", regs_out, 32'h0);
    check("post-reset interrupt", {31'b0, slave_interrupt}, 32'h0);

    // Write then read back-to-back
    xfer(1'b0, 12'h203, 8'hA5, 1'b1, 8'h00);
    check("write-ack regs_out[31:24]", {24'b0, regs_out[31:24]}, 32'hA5);
    xfer(1'b1, 12'h203, 8'h00, 1'b1, 8'hA5);
    idle();

    // Decode and map table
    tbl[0]  = '{1'b0, 12'h303, 8'h5A, 1'b0, 8'h00};
    tbl[1]  = '{1'b0, 12'h204, 8'h77, 1'b1, 8'h00};
    tbl[2]  = '{1'b1, 12'h2FF, 8'h00, 1'b1, 8'h00};
    tbl[3]  = '{1'b1, 12'h203, 8'h00, 1'b1, 8'hA5};
    tbl[4]  = '{1'b1, 12'h204, 8'h00, 1'b1, 8'h00};
    tbl[5]  = '{1'b0, 12'h200, 8'h3C, 1'b1, 8'h00};
    tbl[6]  = '{1'b0, 12'h201, 8'hC3, 1'b1, 8'h00};
    tbl[7]  = '{1'b0, 12'h302, 8'hFF, 1'b0, 8'h00};
    tbl[8]  = '{1'b1, 12'h200, 8'h00, 1'b1, 8'h3C};
    tbl[9]  = '{1'b1, 12'h201, 8'h00, 1'b1, 8'hC3};
    tbl[10] = '{1'b1, 12'h202, 8'h00, 1'b1, 8'h00};
    tbl[11] = '{1'b1, 12'h207, 8'h00, 1'b1, 8'h00};
    for (int i = 0; i < 12; i++) begin
      xfer(tbl[i].rwn, tbl[i].addr, tbl[i].wdata, tbl[i].exp_ack, tbl[i].exp_data);
    end
    idle();
    check("regs_out after table", regs_out, 32'hA500C33C);

    // Interrupt path: enable, then change regs_in
    xfer(1'b0, 12'h206, 8'h01, 1'b1, 8'h00);
    xfer(1'b1, 12'h206, 8'h00, 1'b1, 8'h01);
    regs_in = 16'h0011;
    idle();
    check("intr C+1", {31'b0, slave_interrupt}, 32'h0);
    idle();
    check("intr C+2", {31'b0, slave_interrupt}, 32'h0);
    xfer(1'b1, 12'h207, 8'h00, 1'b1, 8'h01);
    check("intr C+3", {31'b0, slave_interrupt}, 32'h1);
    xfer(1'b1, 12'h204, 8'h00, 1'b1, 8'h11);
    xfer(1'b1, 12'h205, 8'h00, 1'b1, 8'h00);

    // W1C racing a new change: set wins
    regs_in = 16'h0022;
    idle();
    xfer(1'b0, 12'h207, 8'h01, 1'b1, 8'h00);
    xfer(1'b1, 12'h207, 8'h00, 1'b1, 8'h01);
    check("intr after race", {31'b0, slave_interrupt}, 32'h1);
    xfer(1'b1, 12'h204, 8'h00, 1'b1, 8'h22);

    // W1C with stable input clears; interrupt drops one cycle later
    xfer(1'b0, 12'h207, 8'h01, 1'b1, 8'h00);
    check("intr at clear edge", {31'b0, slave_interrupt}, 32'h1);
    xfer(1'b1, 12'h207, 8'h00, 1'b1, 8'h00);
    check("intr after clear", {31'b0, slave_interrupt}, 32'h0);
    idle();

    // Back-to-back writes then reads
    for (int i = 0; i < 4; i++) xfer(1'b0, 12'h200 + 12'(i), 8'h10 + 8'(i), 1'b1, 8'h00);
    for (int i = 0; i < 4; i++) xfer(1'b1, 12'h200 + 12'(i), 8'h00, 1'b1, 8'h10 + 8'(i));
    idle();
    check("regs_out after b2b", regs_out, 32'h13121110);
    check("scoreboard drained", sb.size(), 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
